// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_hold_buf.sv
// rtl/riscv_fetch_hold_buf.sv - one-entry {pc, inst} skid register
module riscv_fetch_hold_buf
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  // Clear wins over load so a redirect always empties the buffer.
  always_comb begin
    pc_d   = pc_q;
    inst_d = inst_q;
    if (clear_i) begin
      pc_d   = '0;
      inst_d = NOP_INST;
    end else if (load_i) begin
      pc_d   = pc_i;
      inst_d = inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      inst_q <= NOP_INST;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
    end
  end

  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage feeding IF/ID
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_plus4_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  hold_pc, hold_inst;
  logic         hold_load, hold_clear;
  logic         accept;
  logic         wait_take, hold_take;
  logic [31:0]  target_pc;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  assign wait_take = (state_q == S_WAIT) & imem_rvalid & ~stall;
  assign hold_take = (state_q == S_HOLD) & ~stall;

  assign imem_req  = ~rst & ~redirect & ((state_q == S_IDLE) | wait_take);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_ready;

  assign hold_load  = ~redirect & (state_q == S_WAIT) & imem_rvalid & stall;
  assign hold_clear = redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    if (redirect) begin
      fetch_pc_d = target_pc;
      case (state_q)
        S_WAIT:  state_d = imem_rvalid ? S_IDLE : S_DRAIN;
        // The stale response still has to be swallowed if it lands now.
        S_DRAIN: state_d = imem_rvalid ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_WAIT: begin
          if (imem_rvalid) state_d = stall ? S_HOLD : S_IDLE;
        end
        S_HOLD:  if (!stall) state_d = S_IDLE;
        S_DRAIN: if (imem_rvalid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (accept) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  riscv_fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .pc_i    (req_pc_q),
    .inst_i  (imem_rdata),
    .pc_o    (hold_pc),
    .inst_o  (hold_inst)
  );

  assign valid_out = ~rst & ~redirect & (wait_take | hold_take);

  always_comb begin
    pc_out   = '0;
    inst_out = NOP_INST;
    if (valid_out) begin
      pc_out   = hold_take ? hold_pc : req_pc_q;
      inst_out = hold_take ? hold_inst : imem_rdata;
    end
  end

  assign pc_plus4_out = pc_out + 32'd4;

endmodule
